// File: rtl/lsu_stage.sv
// Memory stage of the pipeline: issues lane-aligned load/store requests, stalls until
// the memory side responds, formats load data and holds the MEM/WB register.
module lsu_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  RegWriteEnM,
    input  logic                                  MemtoRegM,
    input  logic                                  JALM,
    input  logic                                  MemReadEnM,
    input  logic                                  MemWriteEnM,
    input  logic [1:0]                            SizeM,
    input  logic                                  UnsignedM,
    input  logic [4:0]                            RdM,
    input  logic [XLEN-1:0]                       PcPlus4M,
    input  logic [XLEN-1:0]                       ReadData2M,
    input  logic [XLEN-1:0]                       ALUResultM,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDR_W-$clog2(XLEN/8)-1:0]      mem_addr,
    output logic [XLEN/8-1:0]                     mem_be,
    output logic [XLEN-1:0]                       mem_wdata,
    input  logic                                  mem_ready,
    input  logic                                  mem_rvalid,
    input  logic [XLEN-1:0]                       mem_rdata,
    output logic                                  StallM,
    output logic                                  RegWriteEnW,
    output logic                                  MemtoRegW,
    output logic                                  JALW,
    output logic                                  MisalignW,
    output logic [4:0]                            RdW,
    output logic [XLEN-1:0]                       PcPlus4W,
    output logic [XLEN-1:0]                       ALUResultW,
    output logic [XLEN-1:0]                       ReadDataW
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int LW    = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
    state_t state, state_nx;

    logic             access, is_write, misaligned, aligned;
    logic             req, stall, capture_load;
    logic [OFF_W-1:0] offset;
    logic [3:0]       size_low;
    logic [7:0]       size_mask;
    logic [XLEN-1:0]  shifted, low_mask, load_data;
    logic [LW-1:0]    sign_idx;

    assign offset     = ALUResultM[OFF_W-1:0];
    assign access     = MemReadEnM | MemWriteEnM;
    assign is_write   = MemWriteEnM;
    assign size_low   = (4'd1 << SizeM) - 4'd1;
    assign misaligned = ((offset & size_low[OFF_W-1:0]) != '0) || ((XLEN == 32) && (SizeM == 2'b11));
    assign aligned    = access & ~misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        req          = 1'b0;
        stall        = 1'b0;
        capture_load = 1'b0;
        case (state)
            IDLE: begin
                if (aligned) begin
                    req = 1'b1;
                    if (!(mem_ready && is_write)) begin
                        stall    = 1'b1;
                        state_nx = mem_ready ? WAIT_DATA : WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem_ready) begin
                    if (is_write) begin
                        stall    = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    stall        = 1'b0;
                    capture_load = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_req  = req & ~rst;
    assign StallM   = stall & ~rst;
    assign mem_we   = mem_req & is_write;
    assign mem_addr = ALUResultM[ADDR_W-1:OFF_W];

    always_comb begin
        case (SizeM)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign mem_be = size_mask[NB-1:0] << offset;

    // Store data is replicated so every lane carries it; mem_be selects the live bytes.
    always_comb begin
        case (SizeM)
            2'b00:   mem_wdata = {NB{ReadData2M[7:0]}};
            2'b01:   mem_wdata = {(NB/2){ReadData2M[15:0]}};
            2'b10:   mem_wdata = {(NB/4){ReadData2M[31:0]}};
            default: mem_wdata = ReadData2M;
        endcase
    end

    always_comb begin
        low_mask = '0;
        for (int i = 0; i < XLEN; i++) low_mask[i] = size_mask[i/8];
    end

    assign shifted   = mem_rdata >> {offset, 3'b000};
    assign sign_idx  = LW'((8 << SizeM) - 1);
    // A full-width mask leaves ~low_mask empty, so full loads ignore UnsignedM.
    assign load_data = (shifted & low_mask) | ((!UnsignedM && shifted[sign_idx]) ? ~low_mask : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteEnW <= 1'b0;
            MemtoRegW   <= 1'b0;
            JALW        <= 1'b0;
            MisalignW   <= 1'b0;
            RdW         <= '0;
            PcPlus4W    <= '0;
            ALUResultW  <= '0;
            ReadDataW   <= '0;
        end else if (stall) begin
            RegWriteEnW <= 1'b0;
            MisalignW   <= 1'b0;
        end else begin
            RegWriteEnW <= RegWriteEnM & ~(access & misaligned);
            MisalignW   <= access & misaligned;
            MemtoRegW   <= MemtoRegM;
            JALW        <= JALM;
            RdW         <= RdM;
            PcPlus4W    <= PcPlus4M;
            ALUResultW  <= ALUResultM;
            if (capture_load) ReadDataW <= load_data;
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage (XLEN=64): stores, loads, misalignment, stalls, reset.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM, UnsignedM;
    logic [1:0]  SizeM;
    logic [4:0]  RdM;
    logic [63:0] PcPlus4M, ReadData2M, ALUResultM;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, StallM;
    logic [12:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata, mem_rdata;
    logic        RegWriteEnW, MemtoRegW, JALW, MisalignW;
    logic [4:0]  RdW;
    logic [63:0] PcPlus4W, ALUResultW, ReadDataW;

    int n_cmp  = 0;
    int n_fail = 0;
    int stalls;

    lsu_stage #(.XLEN(64), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
        .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM), .SizeM(SizeM),
        .UnsignedM(UnsignedM), .RdM(RdM), .PcPlus4M(PcPlus4M),
        .ReadData2M(ReadData2M), .ALUResultM(ALUResultM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .StallM(StallM),
        .RegWriteEnW(RegWriteEnW), .MemtoRegW(MemtoRegW), .JALW(JALW),
        .MisalignW(MisalignW), .RdW(RdW), .PcPlus4W(PcPlus4W),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_m();
        RegWriteEnM = 0; MemtoRegM = 0; JALM = 0; MemReadEnM = 0; MemWriteEnM = 0;
        UnsignedM = 0; SizeM = 0; RdM = 0; PcPlus4M = 0; ReadData2M = 0; ALUResultM = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Accepted load, rvalid arriving lat cycles after the acceptance cycle.
    task automatic load_seq(input string tag, input logic [1:0] size, input logic uns,
                            input logic [63:0] addr, input logic [63:0] rdata, input int lat,
                            input logic [7:0] be_exp, input logic [63:0] exp);
        @(negedge clk);
        clear_m();
        MemReadEnM = 1; MemtoRegM = 1; RegWriteEnM = 1; SizeM = size; UnsignedM = uns;
        ALUResultM = addr; RdM = 5'd9; PcPlus4M = addr + 4; mem_ready = 1;
        #1;
        check({tag, "_req"}, mem_req, 1);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_be"}, mem_be, be_exp);
        check({tag, "_addr"}, mem_addr, addr[15:3]);
        check({tag, "_stall0"}, StallM, 1);
        stalls = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        check({tag, "_bubble"}, RegWriteEnW, 0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk); #1;
            check({tag, "_wait_req"}, mem_req, 0);
            if (StallM) stalls++;
        end
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = rdata;
        #1;
        check({tag, "_stall_end"}, StallM, 0);
        @(posedge clk); #1;
        mem_rvalid = 0;
        check({tag, "_data"}, ReadDataW, exp);
        check({tag, "_rwe"}, RegWriteEnW, 1);
        check({tag, "_rd"}, RdW, 9);
        check({tag, "_stalls"}, stalls, lat);
    endtask

    initial begin
        clear_m();
        rst = 1;
        #3;
        check("rst_req", mem_req, 0);
        check("rst_stall", StallM, 0);
        check("rst_rwe", RegWriteEnW, 0);
        check("rst_mis", MisalignW, 0);
        check("rst_rdata", ReadDataW, 0);
        @(negedge clk);
        rst = 0;

        // SB with immediate acceptance
        @(negedge clk);
        clear_m();
        MemWriteEnM = 1; SizeM = 2'b00; ReadData2M = 64'hAB; ALUResultM = 64'h105;
        RdM = 5'd3; PcPlus4M = 64'h1000; mem_ready = 1;
        #1;
        check("sb_req", mem_req, 1);
        check("sb_we", mem_we, 1);
        check("sb_be", mem_be, 8'h20);
        check("sb_wdata", mem_wdata, 64'hABAB_ABAB_ABAB_ABAB);
        check("sb_addr", mem_addr, 13'h20);
        check("sb_stall", StallM, 0);
        @(posedge clk); #1;
        check("sb_aluw", ALUResultW, 64'h105);
        check("sb_pcw", PcPlus4W, 64'h1000);
        check("sb_rdw", RdW, 3);
        check("sb_mis", MisalignW, 0);

        load_seq("lh_s", 2'b01, 1'b0, 64'h102, 64'h0000_0000_8001_0000, 3, 8'h0C, 64'hFFFF_FFFF_FFFF_8001);
        load_seq("lhu", 2'b01, 1'b1, 64'h102, 64'h0000_0000_8001_0000, 3, 8'h0C, 64'h0000_0000_0000_8001);
        load_seq("ldu", 2'b11, 1'b1, 64'h108, 64'h8000_0000_0000_0001, 1, 8'hFF, 64'h8000_0000_0000_0001);
        load_seq("lw_s", 2'b10, 1'b0, 64'h10C, 64'hF000_0000_0000_0000, 2, 8'hF0, 64'hFFFF_FFFF_F000_0000);
        load_seq("lbu", 2'b00, 1'b1, 64'h107, 64'h9A00_0000_0000_0000, 1, 8'h80, 64'h0000_0000_0000_009A);

        // Misaligned SW
        @(negedge clk);
        clear_m();
        MemWriteEnM = 1; RegWriteEnM = 1; SizeM = 2'b10; ALUResultM = 64'h106; RdM = 5'd4;
        #1;
        check("sw_mis_req", mem_req, 0);
        check("sw_mis_stall", StallM, 0);
        @(posedge clk); #1;
        check("sw_mis_flag", MisalignW, 1);
        check("sw_mis_rwe", RegWriteEnW, 0);
        check("sw_mis_alu", ALUResultW, 64'h106);

        // Non-access cycle
        @(negedge clk);
        clear_m();
        RegWriteEnM = 1; JALM = 1; RdM = 5'd7; ALUResultM = 64'h55;
        #1;
        check("alu_req", mem_req, 0);
        @(posedge clk); #1;
        check("alu_rwe", RegWriteEnW, 1);
        check("alu_jal", JALW, 1);
        check("alu_mis", MisalignW, 0);
        check("alu_rdhold", ReadDataW, 64'h9A);

        // SD held off for 4 cycles
        @(negedge clk);
        clear_m();
        MemWriteEnM = 1; RegWriteEnM = 1; SizeM = 2'b11; ALUResultM = 64'h200;
        ReadData2M = 64'h1122_3344_5566_7788; RdM = 5'd2;
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            mem_ready = (i == 4);
            #1;
            check("sd_req", mem_req, 1);
            check("sd_addr", mem_addr, 13'h40);
            check("sd_be", mem_be, 8'hFF);
            check("sd_wdata", mem_wdata, 64'h1122_3344_5566_7788);
            if (StallM) stalls++;
            @(posedge clk); #1;
            if (i < 4) check("sd_bubble", RegWriteEnW, 0);
        end
        check("sd_stalls", stalls, 4);
        check("sd_done_rwe", RegWriteEnW, 1);
        check("sd_done_alu", ALUResultW, 64'h200);
        mem_ready = 0;

        // Reset while waiting for load data
        @(negedge clk);
        clear_m();
        MemReadEnM = 1; RegWriteEnM = 1; SizeM = 2'b10; ALUResultM = 64'h110; RdM = 5'd6;
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        @(negedge clk);
        rst = 1;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_stall", StallM, 0);
        check("arst_rdw", RdW, 0);
        check("arst_aluw", ALUResultW, 0);
        check("arst_pcw", PcPlus4W, 0);
        check("arst_rdata", ReadDataW, 0);
        @(negedge clk);
        rst = 0;
        clear_m();
        mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("late_rv_stall", StallM, 0);
        @(posedge clk); #1;
        mem_rvalid = 0;
        check("late_rv_data", ReadDataW, 0);
        check("late_rv_rwe", RegWriteEnW, 0);
        @(negedge clk);
        MemWriteEnM = 1; SizeM = 2'b00; ALUResultM = 64'h101; ReadData2M = 64'h5A; mem_ready = 1;
        #1;
        check("post_rst_req", mem_req, 1);
        check("post_rst_stall", StallM, 0);
        check("post_rst_be", mem_be, 8'h02);
        @(posedge clk); #1;
        clear_m();
        check("post_rst_rdata", ReadDataW, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter XLEN, default 64, data width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 16, number of byte-address bits decoded from ALUResultM.
REQ-003 clk  in  1  rising-edge clock, single clock domain.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM  in  1 each  EX/MEM control.
REQ-006 SizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-007 UnsignedM  in  1  zero-extend loads when 1 (LBU/LHU/LWU).
REQ-008 RdM  in  5; PcPlus4M, ReadData2M, ALUResultM  in  XLEN each  EX/MEM data.
REQ-009 mem_req, mem_we  out  1 each  memory request and write qualifier.
REQ-010 mem_addr  out  ADDR_W-log2(XLEN/8)  lane-word index, ALUResultM[ADDR_W-1:log2(XLEN/8)].
REQ-011 mem_be  out  XLEN/8  byte enables; mem_wdata  out  XLEN  lane-aligned store data.
REQ-012 mem_ready  in  1  request accepted this cycle; mem_rvalid  in  1, mem_rdata  in  XLEN  read return.
REQ-013 StallM  out  1  MEM access incomplete; upstream holds all M inputs stable while high.
REQ-014 RegWriteEnW, MemtoRegW, JALW, MisalignW  out  1 each; RdW  out  5; PcPlus4W, ALUResultW, ReadDataW  out  XLEN  MEM/WB register.

Function
REQ-015 Access = MemReadEnM or MemWriteEnM; both high is treated as a write, read ignored.
REQ-016 Misaligned = byte offset (ALUResultM[log2(XLEN/8)-1:0]) not a multiple of access size, or SizeM=11 when XLEN=32.
REQ-017 Misaligned access: no mem_req, no stall; next edge MisalignW=1, RegWriteEnW=0, other W fields captured normally.
REQ-018 FSM states IDLE, WAIT_ACK, WAIT_DATA; reset state IDLE.
REQ-019 IDLE, aligned access: mem_req=1 combinationally with mem_we, mem_addr, mem_be, mem_wdata.
REQ-020 IDLE write with mem_ready=1: StallM=0, W register captures, stay IDLE (zero-stall store).
REQ-021 IDLE write with mem_ready=0: StallM=1, go WAIT_ACK; WAIT_ACK holds mem_req=1 and identical fields until mem_ready.
REQ-022 Read accepted (mem_ready=1 in IDLE or WAIT_ACK): go WAIT_DATA, StallM=1; mem_req=0 in WAIT_DATA.
REQ-023 WAIT_DATA with mem_rvalid=1: StallM=0, W register captures formatted load data, go IDLE; min load latency 1 cycle after acceptance.
REQ-024 Write accepted in WAIT_ACK: StallM=0 that cycle, W register captures, go IDLE.
REQ-025 mem_rvalid outside WAIT_DATA is ignored.
REQ-026 While StallM=1, W register loads a bubble: RegWriteEnW=0, MisalignW=0, other W fields hold.
REQ-027 Non-access cycles: no mem_req, StallM=0, W register captures M inputs; ReadDataW holds previous value.
REQ-028 mem_be = size mask (1,3,15,255 bits) shifted left by byte offset; mem_wdata = low size bytes of ReadData2M replicated across all lanes.
REQ-029 Load data = selected bytes of mem_rdata at byte offset, sign-extended to XLEN, or zero-extended when UnsignedM=1; full-XLEN loads ignore UnsignedM.

Reset
REQ-030 rst high forces IDLE immediately, mem_req=0, StallM=0, every W output 0, independent of clk.
REQ-031 Reset mid-transaction abandons the access; a late mem_rvalid after reset release is ignored per REQ-025.

Verification
REQ-032 XLEN=64, SB ReadData2M=0xAB, addr 0x105, mem_ready=1 -> mem_be=0x20, mem_wdata=0xABAB...AB, StallM=0.
REQ-033 LH addr 0x102, mem_ready=1, rvalid 3 cycles later with rdata bytes[3:2]=0x8001 -> StallM high 3 cycles, ReadDataW=0xFFFF_FFFF_FFFF_8001; with UnsignedM=1 -> 0x8001.
REQ-034 SW addr 0x106 -> no mem_req, MisalignW=1, RegWriteEnW=0 next cycle.
REQ-035 SD addr 0x200, mem_ready low 4 cycles -> mem_req and fields stable 5 cycles, StallM high 4, RegWriteEnW bubble throughout.
REQ-036 Assert rst in WAIT_DATA, release, then pulse mem_rvalid -> all W outputs 0, state IDLE, no capture.
REQ-037 LD addr 0x108 rdata 0x8000_0000_0000_0001 with UnsignedM=1 -> ReadDataW=0x8000_0000_0000_0001.
